// File: rtl/usb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// usb_uart_tx_fifo
//
// Byte FIFO between a CPU-side producer and the usb_uart transmit input.
// First-word-fall-through: the head byte is presented on rd_data whenever
// rd_valid is high. Handshakes complete on rising edges of clk_48mhz when
// valid and ready are both high.
//
// Ports
//   clk_48mhz    in   1     sole clock, all state updates on the rising edge
//   reset        in   1     asynchronous active-high reset
//   wr_data      in   8     byte offered by the producer
//   wr_valid     in   1     producer offers wr_data
//   wr_ready     out  1     FIFO accepts a byte this cycle (not full)
//   rd_data      out  8     head byte (valid only while rd_valid = 1)
//   rd_valid     out  1     head byte present (not empty)
//   rd_ready     in   1     consumer takes the head byte
//   level        out  AW+1  number of stored bytes, 0..DEPTH
//   overflow     out  1     sticky: a write was offered while full
//   clr_overflow in   1     synchronous clear of overflow (set wins)
// -----------------------------------------------------------------------------
module usb_uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_48mhz,
    input  logic          reset,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          clr_overflow
);

    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    // Flags are kept as their own flops (computed from the next level) so
    // that neither ready/valid output depends combinationally on an input.
    logic          wr_ready_q, wr_ready_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_fire;
    logic          rd_fire;

    assign wr_fire  = wr_valid & wr_ready_q;
    assign rd_fire  = rd_valid_q & rd_ready;

    assign wr_ready = wr_ready_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    // Pointer wraps naturally because DEPTH is a power of two.
    assign rd_data  = mem_q[rp_q];

    // Next-state computation for pointers, occupancy, flags and overflow.
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (wr_fire) begin
            wp_d = wp_q + PTR_ONE;
        end else begin
            wp_d = wp_q;
        end

        if (rd_fire) begin
            rp_d = rp_q + PTR_ONE;
        end else begin
            rp_d = rp_q;
        end

        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // A refused write sets the flag; setting takes priority over a clear.
        if (wr_valid && !wr_ready_q) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        wr_ready_d = (level_d != LVL_FULL);
        rd_valid_d = (level_d != LVL_ZERO);
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            wp_q       <= {AW{1'b0}};
            rp_q       <= {AW{1'b0}};
            level_q    <= LVL_ZERO;
            overflow_q <= 1'b0;
            wr_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array; contents are never reset, only the pointers are.
    always_ff @(posedge clk_48mhz) begin
        if (wr_fire) begin
            mem_q[wp_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_usb_uart_tx_fifo.sv
module tb_usb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk_48mhz = 1'b0;
    logic        reset     = 1'b0;
    logic [7:0]  wr_data   = 8'h00;
    logic        wr_valid  = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready  = 1'b0;
    logic [AW:0] level;
    logic        overflow;
    logic        clr_overflow = 1'b0;

    usb_uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_48mhz    (clk_48mhz),
        .reset        (reset),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    // Behavioural model: a queue of stored bytes plus the sticky flag.
    logic [7:0] mq[$];
    logic [7:0] out_log[$];
    bit         m_ovf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each edge; reset empties it immediately.
    always @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            bit can_w;
            bit can_r;
            can_w = (mq.size() < DEPTH);
            can_r = (mq.size() > 0);
            if (rd_ready && can_r) begin
                out_log.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (wr_valid && can_w) mq.push_back(wr_data);
            if (wr_valid && !can_w) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
        end
    end

    // Compare process: DUT outputs against the model, away from the edge.
    always @(negedge clk_48mhz) begin
        if (chk_en) begin
            chk("level",    32'(level),    32'(mq.size()));
            chk("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
            chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
        end
    end

    task automatic drive(input logic wv, input logic [7:0] wd, input logic rr, input logic clr);
        wr_valid     = wv;
        wr_data      = wd;
        rd_ready     = rr;
        clr_overflow = clr;
        @(posedge clk_48mhz);
        @(negedge clk_48mhz);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk_48mhz);
        chk("rst_level",    32'(level),    32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Single byte into empty FIFO, then hold.
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        chk("t34_valid", 32'(rd_valid), 32'd1);
        chk("t34_data",  32'(rd_data),  32'h41);
        chk("t34_level", 32'(level),    32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            chk("t34_hold", 32'(rd_data), 32'h41);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t34_drain", 32'(level), 32'd0);

        // Fill to full, overflow, set-vs-clear priority, read back in order.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        chk("t35_full_level", 32'(level),    32'd16);
        chk("t35_full_ready", 32'(wr_ready), 32'd0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("t35_ovf",   32'(overflow), 32'd1);
        chk("t35_level", 32'(level),    32'd16);
        drive(1'b1, 8'hBB, 1'b0, 1'b1);
        chk("set_wins",  32'(overflow), 32'd1);
        out_log.delete();
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t35_count", 32'(out_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < out_log.size(); i++) chk("t35_order", 32'(out_log[i]), 32'(i));
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous read and write.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        out_log.delete();
        drive(1'b1, 8'hCC, 1'b1, 1'b0);
        chk("t38_ovf",   32'(overflow), 32'd1);
        chk("t38_level", 32'(level),    32'd15);
        chk("t38_ready", 32'(wr_ready), 32'd1);
        chk("t38_out",   32'(out_log.size() > 0 ? out_log[0] : 8'hxx), 32'h80);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t38_drain", 32'(level), 32'd0);

        // Stream 40 bytes with irregular read acceptance.
        begin
            int sent = 0;
            int cyc  = 0;
            bit fire;
            out_log.delete();
            while ((sent < 40 || mq.size() != 0) && cyc < 400) begin
                fire = (sent < 40) && wr_ready;
                drive(sent < 40, 8'(8'h10 + sent), ((cyc * 5 + 3) % 7) < 3, 1'b0);
                if (fire) sent++;
                cyc++;
            end
            chk("t36_bound", 32'(cyc < 400), 32'd1);
        end
        chk("t36_count", 32'(out_log.size()), 32'd40);
        for (int i = 0; i < 40 && i < out_log.size(); i++) chk("t36_order", 32'(out_log[i]), 32'(8'h10 + i));
        chk("t36_level", 32'(level), 32'd0);

        // Level 5 with simultaneous write and read for 10 cycles.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        out_log.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
            chk("t37_level", 32'(level), 32'd5);
        end
        chk("t37_count", 32'(out_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < out_log.size(); i++)
            chk("t37_order", 32'(out_log[i]), (i < 5) ? 32'(8'hA0 + i) : 32'(8'hB0 + i - 5));
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t37_drain", 32'(level), 32'd0);

        // Asynchronous reset at level 7, mid-cycle, with a write offered.
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        @(posedge clk_48mhz);
        #2 reset = 1'b1;
        #1;
        chk("t39_level",    32'(level),    32'd0);
        chk("t39_rd_valid", 32'(rd_valid), 32'd0);
        chk("t39_overflow", 32'(overflow), 32'd0);
        chk("t39_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk_48mhz);
        @(negedge clk_48mhz);
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t39_no_fire", 32'(level), 32'd0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        chk("t39_data",  32'(rd_data),  32'h55);
        chk("t39_valid", 32'(rd_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_uart_tx_fifo.md
USB_UART_TX_FIFO -- requirements
Module: usb_uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, 4..256.
REQ-002 SHALL have parameter AW, default 4, pointer width = log2(DEPTH).
REQ-003 SHALL have port clk_48mhz  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_data  input  8  byte from producer (CPU side).
REQ-006 SHALL have port wr_valid  input  1  producer offers wr_data.
REQ-007 SHALL have port wr_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port rd_data  output  8  head byte; drives usb_uart uart_in_data.
REQ-009 SHALL have port rd_valid  output  1  head byte present; drives uart_in_valid.
REQ-010 SHALL have port rd_ready  input  1  consumer takes head; driven by uart_in_ready.
REQ-011 SHALL have port level  output  AW+1  bytes currently stored, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky flag: write attempted while full.
REQ-013 SHALL have port clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-014 SHALL store bytes in a DEPTH x 8 register array with write pointer wp and read pointer rp, each AW bits, plus an AW+1-bit occupancy counter.
REQ-015 SHALL define write handshake wr_fire = wr_valid & wr_ready and read handshake rd_fire = rd_valid & rd_ready.
REQ-016 SHALL drive wr_ready = (level != DEPTH), from registered state only; no combinational path from rd_ready to wr_ready.
REQ-017 SHALL drive rd_valid = (level != 0), from registered state only; no combinational path from wr_valid to rd_valid.
REQ-018 SHALL drive rd_data = mem[rp] (first-word-fall-through); rd_data is don't-care while rd_valid = 0.
REQ-019 On wr_fire, SHALL write wr_data to mem[wp] and increment wp modulo DEPTH.
REQ-020 On rd_fire, SHALL increment rp modulo DEPTH; the byte becomes unavailable on the next cycle.
REQ-021 SHALL update level: +1 on wr_fire only, -1 on rd_fire only, unchanged on both or neither.
REQ-022 Write-to-read latency SHALL be exactly 1 cycle: a byte accepted at edge N is on rd_data with rd_valid = 1 after edge N.
REQ-023 When empty, SHALL NOT bypass; simultaneous wr_fire into an empty FIFO gives rd_valid = 0 in that cycle.
REQ-024 When full, SHALL accept a read in the cycle and reassert wr_ready on the next cycle only; a write offered in the full cycle is refused.
REQ-025 When level is 1..DEPTH-1, simultaneous wr_fire and rd_fire SHALL both complete with level unchanged.
REQ-026 SHALL preserve byte order exactly across pointer wrap-around, with no loss or duplication.
REQ-027 SHALL set overflow to 1 on any cycle with wr_valid = 1 and wr_ready = 0; the refused byte is discarded and state is unchanged.
REQ-028 SHALL clear overflow when clr_overflow = 1; if set and clear coincide, set SHALL win.
REQ-029 Producer SHALL hold wr_data stable while wr_valid = 1 and wr_ready = 0; the FIFO SHALL hold rd_data and rd_valid stable until rd_fire.

Reset
REQ-030 While reset = 1, asynchronously: wp = 0, rp = 0, level = 0, overflow = 0, rd_valid = 0, wr_ready = 1.
REQ-031 Array contents SHALL NOT be reset.
REQ-032 Reset asserted mid-transfer SHALL discard all stored bytes immediately; no handshake fires while reset = 1.
REQ-033 Normal operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-034 Write 0x41 into an empty FIFO with rd_ready = 0 -> next cycle: rd_valid = 1, rd_data = 0x41, level = 1; hold 5 cycles: outputs stable.
REQ-035 Write 0x00..0x0F with rd_ready = 0 -> level = 16, wr_ready = 0; 17th write of 0xAA -> overflow = 1, level stays 16; read all -> 0x00..0x0F in order, 0xAA absent.
REQ-036 Stream 40 bytes 0x10..0x37 with rd_ready toggling pseudo-randomly -> output sequence is identical (wraps pointers twice); final level = 0.
REQ-037 Level 5, wr_valid = 1 and rd_ready = 1 for 10 cycles -> level stays 5, 10 bytes out in order.
REQ-038 Full FIFO, rd_ready = 1 and wr_valid = 1 in the same cycle -> read fires, write refused, overflow = 1; next cycle wr_ready = 1 and level = 15.
REQ-039 Level 7, assert reset asynchronously between edges -> immediately level = 0, rd_valid = 0, overflow = 0; after release, write 0x55 -> rd_data = 0x55 one cycle later.
